// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the async FIFO read-side prefetch logic.
// Imported by the prefetch top and its circular buffer.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int BUF_DEPTH_DEF  = 2;
   localparam int CNT_W_DEF      = $clog2(BUF_DEPTH_DEF + 1);
   localparam int PTR_W_DEF      = $clog2(BUF_DEPTH_DEF);

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular register storage for the read prefetch: write at tail, read at head.
// Pointers wrap naturally because the depth is a power of two.
module fifo_rd_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int PTR_W = ptr_width(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] mem_reg [BUF_DEPTH];
   logic [PTR_W-1:0]      head_reg;
   logic [PTR_W-1:0]      tail_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         if (wr_en) tail_reg <= tail_reg + PTR_W'(1);
         if (rd_en) head_reg <= head_reg + PTR_W'(1);
      end
   end

   // Storage contents survive clear; the pointers alone define what is live.
   always_ff @(posedge clk) begin
      if (wr_en) mem_reg[tail_reg] <= wr_data;
   end

   assign rd_data = mem_reg[head_reg];

endmodule

// File: rtl/async_fifo_rd_prefetch.sv
// Read-side consumer of the async FIFO: turns rd_en/empty/dout into a valid/ready
// stream with a small prefetch buffer for zero-bubble throughput, plus flush.
module async_fifo_rd_prefetch
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
   parameter int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_W-1:0]      level
);

   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             inflight_reg;
   logic             pop;
   logic             capture;
   logic             buf_clr;
   logic [CNT_W:0]   occupancy;

   assign m_valid = ~rd_rst & ~flush & (count_reg != '0);
   assign pop     = m_valid & m_ready;
   assign capture = inflight_reg & ~flush & ~rd_rst;
   assign buf_clr = rd_rst | flush;

   // A word leaving this cycle frees a slot for a read issued this cycle,
   // which is what keeps a two-entry buffer at full rate.
   assign occupancy  = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg)
                     - (CNT_W + 1)'(pop);
   assign fifo_rd_en = ~rd_rst & ~flush & ~fifo_empty & (occupancy < DEPTH_LIM);

   assign level = rd_rst ? '0 : count_reg;

   always_comb begin
      count_next = count_reg;
      case ({capture, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (buf_clr) begin
         count_reg    <= '0;
         inflight_reg <= 1'b0;
      end else begin
         count_reg    <= count_next;
         inflight_reg <= fifo_rd_en;
      end
   end

   fifo_rd_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk     (rd_clk),
      .clr     (buf_clr),
      .wr_en   (capture),
      .wr_data (fifo_dout),
      .rd_en   (pop),
      .rd_data (m_data)
   );

   a_no_overfill: assert property (@(posedge rd_clk) disable iff (rd_rst)
      (int'(count_reg) + int'(inflight_reg)) <= BUF_DEPTH);

   a_capture_room: assert property (@(posedge rd_clk) disable iff (rd_rst)
      capture |-> ((int'(count_reg) < BUF_DEPTH) || pop));

endmodule

// File: tb/tb_async_fifo_rd_prefetch.sv
// Randomised and directed bench for async_fifo_rd_prefetch against a queue-based
// model of the FIFO source, the in-flight word and the prefetch buffer.
module tb_async_fifo_rd_prefetch;

   localparam int DW    = 16;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout = '0;
   logic          flush = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [CW-1:0] level;

   async_fifo_rd_prefetch #(
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (DEPTH)
   ) dut (
      .rd_clk     (rd_clk),
      .rd_rst     (rd_rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .level      (level)
   );

   always #5 rd_clk = ~rd_clk;

   int            vec_cnt = 0;
   int            err_cnt = 0;
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] fly_q[$];
   logic [DW-1:0] buf_q[$];
   logic [DW-1:0] rx_q[$];
   logic          src_hold = 1'b0;
   logic [DW-1:0] dout_next = '0;
   logic          dout_pend = 1'b0;
   logic [DW-1:0] next_word = 16'h0001;
   int            cyc, first_v, last_v, rd_cnt, beat_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic phase_start();
      rx_q.delete();
      cyc      = 0;
      first_v  = -1;
      last_v   = -1;
      rd_cnt   = 0;
      beat_cnt = 0;
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         src_q.push_back(next_word);
         next_word++;
      end
   endtask

   // Compare received beats rx_q[idx0 +: n] against consecutive words from start.
   task automatic chk_run(input string tag, input int idx0, input int start, input int n);
      for (int i = 0; i < n; i++) begin
         if (idx0 + i < rx_q.size())
            chk(tag, 32'(rx_q[idx0 + i]), 32'(start + i));
         else
            chk(tag, 32'hFFFF_FFFF, 32'(start + i));
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, check settled outputs
   // against the model, then advance the model and the FIFO source.
   task automatic cycle(input logic rdy, input logic fl, input logic rst_i);
      logic exp_v, exp_rd, pop;
      int   occ;
      @(negedge rd_clk);
      fifo_dout  = dout_pend ? dout_next : DW'($urandom);
      m_ready    = rdy;
      flush      = fl;
      rd_rst     = rst_i;
      fifo_empty = (src_q.size() == 0) || src_hold;
      #1;
      exp_v  = !rst_i && !fl && (buf_q.size() != 0);
      pop    = exp_v && rdy;
      occ    = buf_q.size() + fly_q.size() - (pop ? 1 : 0);
      exp_rd = !rst_i && !fl && !fifo_empty && (occ < DEPTH);
      chk("m_valid", 32'(m_valid), 32'(exp_v));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      chk("level", 32'(level), rst_i ? 32'd0 : 32'(buf_q.size()));
      if (exp_v) chk("m_data", 32'(m_data), 32'(buf_q[0]));
      if (m_valid && m_ready) begin
         rx_q.push_back(m_data);
         beat_cnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         $display("beat cyc=%0d data=%04h level=%0d", cyc, m_data, level);
      end
      if (fifo_rd_en) rd_cnt++;
      dout_pend = 1'b0;
      if (rst_i || fl) begin
         buf_q.delete();
         fly_q.delete();
      end else begin
         if (pop) void'(buf_q.pop_front());
         if (fly_q.size() != 0) buf_q.push_back(fly_q.pop_front());
      end
      if (fifo_rd_en && src_q.size() != 0) begin
         dout_next = src_q.pop_front();
         dout_pend = 1'b1;
         if (exp_rd) fly_q.push_back(dout_next);
      end
      cyc++;
   endtask

   initial begin
      phase_start();
      repeat (3) cycle(1'b0, 1'b0, 1'b1);

      // Full-rate stream of 8 words
      src_hold = 1'b1; next_word = 16'h0001; load(8); cycle(1'b1, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      chk("p1_latency", 32'(first_v), 32'd2);
      chk("p1_no_bubble", 32'(last_v - first_v), 32'd7);
      chk("p1_beats", 32'(beat_cnt), 32'd8);
      chk("p1_rd_cnt", 32'(rd_cnt), 32'd8);
      chk_run("p1_order", 0, 1, 8);

      // Backpressure: stall then release
      src_hold = 1'b1; next_word = 16'h0001; load(8); cycle(1'b0, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      chk("p2_rd_cnt", 32'(rd_cnt), 32'd2);
      chk("p2_level", 32'(level), 32'd2);
      chk("p2_hold_data", 32'(m_data), 32'h0001);
      chk("p2_valid", 32'(m_valid), 32'd1);
      phase_start();
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      chk("p2_beats", 32'(beat_cnt), 32'd8);
      chk_run("p2_order", 0, 1, 8);

      // Ready toggling every cycle
      src_hold = 1'b1; next_word = 16'h0001; load(16); cycle(1'b0, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      for (int i = 0; i < 48; i++) cycle(i % 2 == 0, 1'b0, 1'b0);
      chk("p3_beats", 32'(beat_cnt), 32'd16);
      chk_run("p3_order", 0, 1, 16);

      // Flush while word 3 is in flight
      src_hold = 1'b1; next_word = 16'h0001; load(8); cycle(1'b0, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      chk("p4_beats", 32'(rx_q.size()), 32'd6);
      chk_run("p4_pre", 0, 1, 1);
      chk_run("p4_post", 1, 4, 5);

      // FIFO runs dry after 3 words, then refills
      src_hold = 1'b1; next_word = 16'h0001; load(3); cycle(1'b0, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      repeat (8) cycle(1'b1, 1'b0, 1'b0);
      chk("p5_beats", 32'(beat_cnt), 32'd3);
      chk("p5_rd_cnt", 32'(rd_cnt), 32'd3);
      chk("p5_valid_low", 32'(m_valid), 32'd0);
      phase_start(); load(2);
      repeat (6) cycle(1'b1, 1'b0, 1'b0);
      chk("p5_relatency", 32'(first_v), 32'd2);
      chk_run("p5_order", 0, 4, 2);

      // Reset pulse mid-stream
      src_hold = 1'b1; next_word = 16'h0001; load(8); cycle(1'b0, 1'b0, 1'b0);
      src_hold = 1'b0; phase_start();
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      chk("p6_level_pre", 32'(level), 32'd1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      chk("p6_level_post", 32'(level), 32'd0);
      chk("p6_valid_post", 32'(m_valid), 32'd0);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      chk("p6_beats", 32'(rx_q.size()), 32'd6);
      chk_run("p6_pre", 0, 1, 1);
      chk_run("p6_post", 1, 4, 5);

      // Random traffic: backpressure, source gaps, flushes and resets
      phase_start();
      for (int i = 0; i < 800; i++) begin
         if (src_q.size() < 4 && $urandom_range(0, 3) == 0) load($urandom_range(1, 6));
         src_hold = ($urandom_range(0, 9) == 0);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 99) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
